// File: rtl/nvdla_rwsp_rd_seq.sv
// Burst read sequencer for a two-stage registered RAM: issues reads under a
// credit limit and streams returned entries through a small flop FIFO.
module nvdla_rwsp_rd_seq #(
    parameter int DEPTH = 80,
    parameter int AW    = 7,
    parameter int DW    = 256,
    parameter int FD    = 4
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    output logic          dat_valid,
    input  logic          dat_ready,
    output logic [DW-1:0] dat_pd,
    output logic          dat_last,
    output logic          busy
);
    localparam int CW = $clog2(FD + 1);
    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q;
    logic [AW-1:0] cur_addr_q, remain_q, ra_q;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [PW-1:0] wp_q, rp_q;
    logic [2:1]    vld_pipe_q, last_pipe_q;
    logic [DW-1:0] mem_q [FD];
    logic [FD-1:0] mlast_q;
    logic          issue, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit covers FIFO occupancy plus reads still in the RAM pipeline,
    // so a push can never find the FIFO full.
    assign req_ready = (state_q == IDLE);
    assign issue     = (state_q == RUN) && (credit_q < CW'(FD));
    assign push      = vld_pipe_q[2];
    assign pop       = dat_valid && dat_ready;
    assign ram_re    = issue;
    assign ram_ra    = issue ? cur_addr_q : ra_q;
    assign ram_ore   = vld_pipe_q[1];
    assign dat_valid = (fcnt_q != '0);
    assign dat_pd    = mem_q[rp_q];
    assign dat_last  = mlast_q[rp_q];
    assign busy      = (state_q == RUN) || (vld_pipe_q != '0) || dat_valid;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            ra_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    cur_addr_q <= (req_addr >= AW'(DEPTH)) ? '0 : req_addr;
                    remain_q   <= (req_len > LAST_ADDR) ? LAST_ADDR : req_len;
                    state_q    <= RUN;
                end
                RUN: if (issue) begin
                    ra_q       <= cur_addr_q;
                    cur_addr_q <= (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + AW'(1);
                    remain_q   <= remain_q - AW'(1);
                    if (remain_q == '0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        credit_d = credit_q;
        if (issue && !pop)      credit_d = credit_q + CW'(1);
        else if (!issue && pop) credit_d = credit_q - CW'(1);
        fcnt_d = fcnt_q;
        if (push && !pop)       fcnt_d = fcnt_q + CW'(1);
        else if (!push && pop)  fcnt_d = fcnt_q - CW'(1);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            credit_q    <= '0;
            fcnt_q      <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            credit_q    <= credit_d;
            fcnt_q      <= fcnt_d;
            vld_pipe_q  <= {vld_pipe_q[1], issue};
            last_pipe_q <= {last_pipe_q[1], issue && (remain_q == '0)};
        end
    end

    // ram_dout is only meaningful in the stage-2 slot; it is captured there.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wp_q    <= '0;
            rp_q    <= '0;
            mlast_q <= '0;
            for (int i = 0; i < FD; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wp_q]   <= ram_dout;
                mlast_q[wp_q] <= last_pipe_q[2];
                wp_q          <= ptr_inc(wp_q);
            end
            if (pop) rp_q <= ptr_inc(rp_q);
        end
    end

endmodule
